// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length codes, schedule-size lookups, FSM states
// and the byte/word substitution helpers used by the key schedule and cipher rounds.
package aes_pkg;

  localparam logic [1:0] KEY_128 = 2'b00;
  localparam logic [1:0] KEY_192 = 2'b01;
  localparam logic [1:0] KEY_256 = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_EXPAND = 2'b01,
    S_EMIT   = 2'b10
  } state_t;

  // Forward S-box, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(input logic [1:0] key_len);
    case (key_len)
      KEY_128: return 4'd4;
      KEY_192: return 4'd6;
      KEY_256: return 4'd8;
      default: return 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KEY_128: return 4'd10;
      KEY_192: return 4'd12;
      KEY_256: return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 255 - x equals ~x for a byte, which selects the table entry from the top.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};
    return SBOX[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_lookup(w[31:24]), sbox_lookup(w[23:16]),
            sbox_lookup(w[15:8]),  sbox_lookup(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational 8-bit AES forward S-box, shared by key schedule and cipher rounds.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_lookup(a);

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128/192/256 key schedule: one word per cycle into a 60-word store,
// then round keys streamed over valid/ready in forward or reverse order.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter bit ALLOW_192  = 1'b1,
  parameter bit REVERSE_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   key_len,
  input  logic         dir,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         err,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_data,
  output logic [3:0]   rk_index,
  output logic         rk_last,
  output logic         done
);

  state_t      state;
  logic [3:0]  nk;
  logic [3:0]  nr;
  logic        dir_q;
  logic [5:0]  widx;
  logic [2:0]  wrap;
  logic [7:0]  rcon;
  logic [3:0]  rnd;
  logic [31:0] store [0:59];

  logic         legal;
  logic [31:0]  prev_w;
  logic [31:0]  old_w;
  logic [31:0]  sbox_in;
  logic [31:0]  sub_w;
  logic [31:0]  temp_w;
  logic [31:0]  new_w;
  logic         last_word;
  logic         wrap_end;
  logic [5:0]   rd_base;
  logic [127:0] rd_key;
  logic [3:0]   last_rnd;
  logic [3:0]   rnd_next;
  logic         handshake;

  // Legality of the requested key length.
  always_comb begin
    legal = 1'b0;
    if (key_len == KEY_128 || key_len == KEY_256) begin
      legal = 1'b1;
    end else if (key_len == KEY_192) begin
      legal = ALLOW_192;
    end else begin
      legal = 1'b0;
    end
  end

  // Next-word datapath; wrap tracks i mod Nk so no divider is needed.
  always_comb begin
    prev_w    = store[widx - 6'd1];
    old_w     = store[widx - {2'b00, nk}];
    sbox_in   = prev_w;
    temp_w    = prev_w;
    if (wrap == 3'd0) begin
      sbox_in = {prev_w[23:0], prev_w[31:24]};
      temp_w  = sub_w ^ {rcon, 24'h000000};
    end else if (nk == 4'd8 && wrap == 3'd4) begin
      sbox_in = prev_w;
      temp_w  = sub_w;
    end else begin
      sbox_in = prev_w;
      temp_w  = prev_w;
    end
    new_w     = old_w ^ temp_w;
    last_word = (widx == ({nr, 2'b00} + 6'd3));
    wrap_end  = ({1'b0, wrap} == (nk - 4'd1));
  end

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes_sbox u_sbox (
      .a (sbox_in[8*b +: 8]),
      .y (sub_w[8*b +: 8])
    );
  end

  // Round-key read port and emit-order stepping.
  always_comb begin
    rd_base   = {rnd, 2'b00};
    rd_key    = {store[rd_base], store[rd_base + 6'd1],
                 store[rd_base + 6'd2], store[rd_base + 6'd3]};
    last_rnd  = dir_q ? 4'd0 : nr;
    handshake = rk_valid & rk_ready;
    rnd_next  = rnd;
    if (rnd == last_rnd) begin
      rnd_next = rnd;
    end else if (dir_q) begin
      rnd_next = rnd - 4'd1;
    end else begin
      rnd_next = rnd + 4'd1;
    end
  end

  // Word store: cipher key on accept, one expanded word per EXPAND cycle.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start && legal) begin
      for (int k = 0; k < 8; k++) begin
        store[k] <= key_in[255 - 32*k -: 32];
      end
    end else if (state == S_EXPAND) begin
      store[widx] <= new_w;
    end
  end

  // Sequencer and registered round-key port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      nk       <= 4'd4;
      nr       <= 4'd10;
      dir_q    <= 1'b0;
      widx     <= 6'd0;
      wrap     <= 3'd0;
      rcon     <= 8'h01;
      rnd      <= 4'd0;
      busy     <= 1'b0;
      err      <= 1'b0;
      done     <= 1'b0;
      rk_valid <= 1'b0;
      rk_data  <= 128'd0;
      rk_index <= 4'd0;
      rk_last  <= 1'b0;
    end else begin
      err  <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (legal) begin
              nk    <= nk_of(key_len);
              nr    <= nr_of(key_len);
              dir_q <= REVERSE_EN ? dir : 1'b0;
              widx  <= {2'b00, nk_of(key_len)};
              wrap  <= 3'd0;
              rcon  <= 8'h01;
              busy  <= 1'b1;
              state <= S_EXPAND;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_EXPAND: begin
          if (wrap == 3'd0) begin
            rcon <= xtime(rcon);
          end
          wrap <= wrap_end ? 3'd0 : wrap + 3'd1;
          widx <= widx + 6'd1;
          if (last_word) begin
            rnd   <= dir_q ? nr : 4'd0;
            state <= S_EMIT;
          end
        end
        S_EMIT: begin
          // A non-final handshake reloads in the same edge, so valid never bubbles.
          if (!rk_valid || (handshake && !rk_last)) begin
            rk_data  <= rd_key;
            rk_index <= rnd;
            rk_last  <= (rnd == last_rnd);
            rk_valid <= 1'b1;
            rnd      <= rnd_next;
          end else if (handshake) begin
            rk_valid <= 1'b0;
            rk_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Directed self-checking bench for aes_key_schedule_seq using FIPS-197 key expansion vectors.
module tb_aes_key_schedule_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   key_len;
  logic         dir;
  logic [255:0] key_in;
  logic         busy, err, rk_valid, rk_last, done;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_index;

  logic         start2;
  logic         busy2, err2, rk_valid2, rk_last2, done2;
  logic [127:0] rk_data2;
  logic [3:0]   rk_index2;

  int checks = 0;
  int failures = 0;

  logic [127:0] keys  [0:14];
  logic [3:0]   idxs  [0:14];
  logic         lasts [0:14];
  logic [127:0] ref128 [0:10];
  logic [127:0] ref256 [0:14];
  logic [3:0]   ref256_i [0:14];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_schedule_seq #(.ALLOW_192(1'b1), .REVERSE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .key_len(key_len), .dir(dir), .key_in(key_in),
    .busy(busy), .err(err), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last), .done(done)
  );

  aes_key_schedule_seq #(.ALLOW_192(1'b0), .REVERSE_EN(1'b1)) dut_no192 (
    .clk(clk), .rst(rst), .start(start2), .key_len(2'b01), .dir(1'b0), .key_in(K192),
    .busy(busy2), .err(err2), .rk_valid(rk_valid2), .rk_ready(1'b1), .rk_data(rk_data2),
    .rk_index(rk_index2), .rk_last(rk_last2), .done(done2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Start one operation, check latency, collect every handshaken key.
  task automatic run_op(input logic [1:0] kl, input logic d, input logic [255:0] key,
                        input bit stall, input bit poke, input int exp_lat, input int exp_n);
    int lat;
    int n;
    int guard;
    bit rdy;
    logic [127:0] hd;
    logic [3:0] hi;
    logic hl;
    key_len = kl; dir = d; key_in = key; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    check("busy_after_start", busy, 1'b1);
    while (!rk_valid && lat < 300) begin
      if (poke && lat == 10) begin
        start = 1'b1; key_len = 2'b11;
        tick();
        lat++;
        start = 1'b0; key_len = kl;
        check("start_in_expand_no_err", err, 1'b0);
        check("start_in_expand_busy", busy, 1'b1);
      end else begin
        tick();
        lat++;
      end
    end
    check("first_valid_latency", lat, exp_lat);
    n = 0;
    guard = 0;
    while (n < exp_n && guard < 2000) begin
      guard++;
      rdy = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      rk_ready = rdy;
      hd = rk_data; hi = rk_index; hl = rk_last;
      if (rk_valid && rdy) begin
        tick();
        keys[n] = hd; idxs[n] = hi; lasts[n] = hl;
        n++;
      end else begin
        tick();
        if (stall && !rdy) begin
          check("stall_data_stable", rk_data, hd);
          check("stall_index_stable", rk_index, hi);
          check("stall_valid_held", rk_valid, 1'b1);
        end
      end
    end
    rk_ready = 1'b0;
    check("key_count", n, exp_n);
    check("done_pulse", done, 1'b1);
    check("busy_low_at_done", busy, 1'b0);
    check("valid_low_at_done", rk_valid, 1'b0);
    tick();
    check("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; key_len = 2'b00; dir = 1'b0;
    key_in = 256'd0; rk_ready = 1'b0;
    tick(); tick();
    check("reset_flags", {busy, err, rk_valid, rk_last, done}, 5'b00000);
    check("reset_data", rk_data, 128'd0);
    check("reset_index", rk_index, 4'd0);
    rst = 1'b0;
    tick();

    // AES-128 forward
    run_op(2'b00, 1'b0, K128, 1'b0, 1'b0, 42, 11);
    check("k128_key0", keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
    check("k128_key1", keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("k128_key10", keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("k128_idx0", idxs[0], 4'd0);
    check("k128_idx10", idxs[10], 4'd10);
    check("k128_last10", lasts[10], 1'b1);
    check("k128_last9", lasts[9], 1'b0);
    for (int k = 0; k < 11; k++) ref128[k] = keys[k];

    // AES-192 forward
    run_op(2'b01, 1'b0, K192, 1'b0, 1'b0, 48, 13);
    check("k192_key0", keys[0], 128'h8e73b0f7da0e6452c810f32b809079e5);
    check("k192_key12", keys[12], 128'he98ba06f448c773c8ecc720401002202);
    check("k192_idx12", idxs[12], 4'd12);
    check("k192_last12", lasts[12], 1'b1);

    // AES-256 reverse
    run_op(2'b10, 1'b1, K256, 1'b0, 1'b0, 54, 15);
    check("k256_first_key", keys[0], 128'hfe4890d1e6188d0b046df344706c631e);
    check("k256_first_idx", idxs[0], 4'd14);
    check("k256_last_key", keys[14], 128'h603deb1015ca71be2b73aef0857d7781);
    check("k256_last_idx", idxs[14], 4'd0);
    check("k256_last_flag", lasts[14], 1'b1);
    check("k256_first_not_last", lasts[0], 1'b0);
    for (int k = 0; k < 15; k++) begin
      ref256[k] = keys[k];
      ref256_i[k] = idxs[k];
    end

    // AES-256 reverse with random backpressure
    run_op(2'b10, 1'b1, K256, 1'b1, 1'b0, 54, 15);
    for (int k = 0; k < 15; k++) begin
      check("k256_stall_key", keys[k], ref256[k]);
      check("k256_stall_idx", idxs[k], ref256_i[k]);
    end

    // Illegal key length
    key_len = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    check("illegal_err", err, 1'b1);
    check("illegal_busy", busy, 1'b0);
    tick();
    check("illegal_err_pulse", err, 1'b0);
    check("illegal_stays_idle", busy, 1'b0);

    // 192-bit start on the instance without 192 support
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    check("no192_err", err2, 1'b1);
    check("no192_busy", busy2, 1'b0);
    tick();
    check("no192_err_pulse", err2, 1'b0);

    // Start during EXPAND is ignored and the run completes unchanged
    run_op(2'b00, 1'b0, K128, 1'b0, 1'b1, 42, 11);
    for (int k = 0; k < 11; k++) check("poke_run_key", keys[k], ref128[k]);

    // Reset in the middle of EXPAND
    key_len = 2'b00; dir = 1'b0; key_in = K128; start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 20; c++) tick();
    check("pre_reset_busy", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_flags", {busy, err, rk_valid, rk_last, done}, 5'b00000);
    check("midrst_data", rk_data, 128'd0);
    check("midrst_index", rk_index, 4'd0);
    tick();
    rst = 1'b0;
    tick();
    run_op(2'b00, 1'b0, K128, 1'b0, 1'b0, 42, 11);
    for (int k = 0; k < 11; k++) check("post_reset_key", keys[k], ref128[k]);
    check("post_reset_idx10", idxs[10], 4'd10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
